// File: rtl/ibex_pext_multdiv_seq_if.sv
// ----------------------------------------------------------------------------
// ibex_pext_multdiv_seq_if
// Request/response handshake between the decode stage, the P-extension
// multicycle mult/div sequencer and the writeback consumer.
//   req_valid_i  : decode presents an operation
//   req_ready_o  : sequencer can accept an operation
//   req_is_div_i : 1 = divide/remainder class, 0 = multiply class
//   req_kill_i   : flush the current operation
//   rsp_valid_o  : buffered result available
//   rsp_ready_i  : consumer accepts the result
//   rsp_result_o : buffered 32-bit result
//   rsp_timeout_o: result came from a watchdog abort
// master = decode/writeback side, slave = sequencer.
// ----------------------------------------------------------------------------
interface ibex_pext_multdiv_seq_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_is_div_i;
   logic        req_kill_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_result_o;
   logic        rsp_timeout_o;

   modport master (
      output req_valid_i, req_is_div_i, req_kill_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_timeout_o
   );

   modport slave (
      input  req_valid_i, req_is_div_i, req_kill_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_result_o, rsp_timeout_o
   );
endinterface

// File: rtl/ibex_pext_multdiv_seq.sv
// ----------------------------------------------------------------------------
// ibex_pext_multdiv_seq
// Sequencer for the multicycle multiply/divide path of the P-extension ALU.
// Accepts one operation at a time, drives the ALU mult/div enables and
// selects, owns the two intermediate-value registers the ALU reads back
// between cycles, buffers the final result until writeback accepts it, and
// provides flush (kill) plus a watchdog that forces completion.
//
// Ports:
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   bus (slave)             : request/response handshake (see interface)
//   mult_en_o/div_en_o      : ALU mult_en_i / div_en_i
//   mult_sel_o/div_sel_o    : ALU mult_sel_i / div_sel_i
//   multdiv_ready_id_o      : ALU multdiv_ready_id_i
//   imd_val_d_i/_we_i       : intermediate-value write data/enables from ALU
//   imd_val_q_o             : intermediate-value registers back to ALU
//   alu_valid_i/result_i    : ALU completion and result
//   busy_o                  : an operation is in flight or awaiting pickup
//   ops_cnt_o               : operations completed normally (wraps)
// ----------------------------------------------------------------------------
module ibex_pext_multdiv_seq #(
   parameter int IMD_W      = 34,
   parameter int MAX_CYCLES = 40,
   parameter int CNT_W      = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   ibex_pext_multdiv_seq_if.slave bus,
   output logic                 mult_en_o,
   output logic                 div_en_o,
   output logic                 mult_sel_o,
   output logic                 div_sel_o,
   output logic                 multdiv_ready_id_o,
   input  logic [IMD_W-1:0]     imd_val_d_i [2],
   input  logic [1:0]           imd_val_we_i,
   output logic [IMD_W-1:0]     imd_val_q_o [2],
   input  logic                 alu_valid_i,
   input  logic [31:0]          alu_result_i,
   output logic                 busy_o,
   output logic [CNT_W-1:0]     ops_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // MAX_CYCLES is at most 255, so an 8-bit cycle counter always suffices.
   localparam logic [7:0]       WD_LAST = 8'(MAX_CYCLES - 1);
   localparam logic [7:0]       CYC_ONE = 8'd1;
   localparam logic [CNT_W-1:0] OPS_ONE = CNT_W'(1);

   state_e             state_r;
   state_e             state_nxt_s;
   logic               is_div_r;
   logic               is_div_nxt_s;
   logic               accept_s;
   logic               kill_s;
   logic               wd_hit_s;
   logic               finish_ok_s;
   logic               finish_wd_s;

   logic [7:0]         cyc_cnt_r;
   logic [IMD_W-1:0]   imd_val_q_r [2];
   logic [31:0]        rsp_result_r;
   logic               rsp_timeout_r;
   logic [CNT_W-1:0]   ops_cnt_r;

   logic               req_ready_r;
   logic               rsp_valid_r;
   logic               busy_r;
   logic               mult_en_r;
   logic               div_en_r;
   logic               multdiv_ready_r;

   // Next-state decode; kill outranks every other event outside IDLE.
   always_comb begin
      state_nxt_s  = state_r;
      is_div_nxt_s = is_div_r;
      accept_s     = 1'b0;
      finish_ok_s  = 1'b0;
      finish_wd_s  = 1'b0;
      kill_s       = bus.req_kill_i;
      wd_hit_s     = (cyc_cnt_r == WD_LAST);
      case (state_r)
         ST_IDLE: begin
            if (bus.req_valid_i && !kill_s) begin
               accept_s     = 1'b1;
               is_div_nxt_s = bus.req_is_div_i;
               state_nxt_s  = ST_RUN;
            end else begin
               state_nxt_s  = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (kill_s) begin
               state_nxt_s = ST_IDLE;
            end else if (alu_valid_i) begin
               // A valid result on the watchdog cycle still wins.
               finish_ok_s = 1'b1;
               state_nxt_s = ST_DONE;
            end else if (wd_hit_s) begin
               finish_wd_s = 1'b1;
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (kill_s || bus.rsp_ready_i) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM state plus registered control outputs decoded from the next state,
   // so nothing on req_* reaches the ALU controls combinationally.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r         <= ST_IDLE;
         is_div_r        <= 1'b0;
         busy_r          <= 1'b0;
         req_ready_r     <= 1'b1;
         rsp_valid_r     <= 1'b0;
         mult_en_r       <= 1'b0;
         div_en_r        <= 1'b0;
         multdiv_ready_r <= 1'b0;
      end else begin
         state_r         <= state_nxt_s;
         is_div_r        <= is_div_nxt_s;
         busy_r          <= (state_nxt_s != ST_IDLE);
         req_ready_r     <= (state_nxt_s == ST_IDLE);
         rsp_valid_r     <= (state_nxt_s == ST_DONE);
         mult_en_r       <= (state_nxt_s == ST_RUN) && !is_div_nxt_s;
         div_en_r        <= (state_nxt_s == ST_RUN) &&  is_div_nxt_s;
         multdiv_ready_r <= (state_nxt_s == ST_RUN);
      end
   end

   // Cycle counter: cleared on accept, counts every RUN cycle for the watchdog.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cyc_cnt_r <= 8'd0;
      end else if (accept_s) begin
         cyc_cnt_r <= 8'd0;
      end else if (state_r == ST_RUN) begin
         cyc_cnt_r <= cyc_cnt_r + CYC_ONE;
      end else begin
         cyc_cnt_r <= cyc_cnt_r;
      end
   end

   // Intermediate-value registers: ALU writes land only in RUN; a new accept
   // or a kill of an active operation wipes them.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int r = 0; r < 2; r++) begin
            imd_val_q_r[r] <= {IMD_W{1'b0}};
         end
      end else if (accept_s || (kill_s && (state_r != ST_IDLE))) begin
         for (int r = 0; r < 2; r++) begin
            imd_val_q_r[r] <= {IMD_W{1'b0}};
         end
      end else if (state_r == ST_RUN) begin
         for (int r = 0; r < 2; r++) begin
            if (imd_val_we_i[r]) begin
               imd_val_q_r[r] <= imd_val_d_i[r];
            end else begin
               imd_val_q_r[r] <= imd_val_q_r[r];
            end
         end
      end else begin
         for (int r = 0; r < 2; r++) begin
            imd_val_q_r[r] <= imd_val_q_r[r];
         end
      end
   end

   // Response buffer and completion counter; watchdog aborts return zero and
   // do not count as completed operations.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_result_r  <= 32'd0;
         rsp_timeout_r <= 1'b0;
         ops_cnt_r     <= {CNT_W{1'b0}};
      end else if (finish_ok_s) begin
         rsp_result_r  <= alu_result_i;
         rsp_timeout_r <= 1'b0;
         ops_cnt_r     <= ops_cnt_r + OPS_ONE;
      end else if (finish_wd_s) begin
         rsp_result_r  <= 32'd0;
         rsp_timeout_r <= 1'b1;
         ops_cnt_r     <= ops_cnt_r;
      end else begin
         rsp_result_r  <= rsp_result_r;
         rsp_timeout_r <= rsp_timeout_r;
         ops_cnt_r     <= ops_cnt_r;
      end
   end

   assign bus.req_ready_o   = req_ready_r;
   assign bus.rsp_valid_o   = rsp_valid_r;
   assign bus.rsp_result_o  = rsp_result_r;
   assign bus.rsp_timeout_o = rsp_timeout_r;

   assign mult_en_o          = mult_en_r;
   assign mult_sel_o         = mult_en_r;
   assign div_en_o           = div_en_r;
   assign div_sel_o          = div_en_r;
   assign multdiv_ready_id_o = multdiv_ready_r;
   assign imd_val_q_o[0]     = imd_val_q_r[0];
   assign imd_val_q_o[1]     = imd_val_q_r[1];
   assign busy_o             = busy_r;
   assign ops_cnt_o          = ops_cnt_r;

endmodule

// File: tb/tb_ibex_pext_multdiv_seq.sv
// ----------------------------------------------------------------------------
// Testbench for ibex_pext_multdiv_seq, built with MAX_CYCLES = 4 and
// CNT_W = 2 so the watchdog and counter wrap are reachable quickly.
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_ibex_pext_multdiv_seq;

   logic        clk;
   logic        rst_ni;
   logic        mult_en, div_en, mult_sel, div_sel, mdr;
   logic [33:0] imd_d [2];
   logic [1:0]  imd_we;
   logic [33:0] imd_q [2];
   logic        alu_valid;
   logic [31:0] alu_result;
   logic        busy;
   logic [1:0]  ops_cnt;

   int checks   = 0;
   int failures = 0;

   ibex_pext_multdiv_seq_if bus ();

   ibex_pext_multdiv_seq #(
      .IMD_W      (34),
      .MAX_CYCLES (4),
      .CNT_W      (2)
   ) dut (
      .clk_i              (clk),
      .rst_ni             (rst_ni),
      .bus                (bus.slave),
      .mult_en_o          (mult_en),
      .div_en_o           (div_en),
      .mult_sel_o         (mult_sel),
      .div_sel_o          (div_sel),
      .multdiv_ready_id_o (mdr),
      .imd_val_d_i        (imd_d),
      .imd_val_we_i       (imd_we),
      .imd_val_q_o        (imd_q),
      .alu_valid_i        (alu_valid),
      .alu_result_i       (alu_result),
      .busy_o             (busy),
      .ops_cnt_o          (ops_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        is_div;
      int          vcyc;     // RUN cycle on which alu_valid pulses; 0 = never
      logic [31:0] alu_res;
      int          hold;     // DONE cycles with rsp_ready low
      int          exp_en;   // expected enabled RUN cycles
      logic [31:0] exp_res;
      logic        exp_to;
      logic [1:0]  exp_ops;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int en;
      int cyc;
      @(negedge clk);
      chk($sformatf("v%0d_req_ready", idx), 64'(bus.req_ready_o), 64'd1);
      bus.req_valid_i  = 1'b1;
      bus.req_is_div_i = v.is_div;
      @(negedge clk);
      bus.req_valid_i  = 1'b0;
      bus.req_is_div_i = 1'b0;
      en  = 0;
      cyc = 1;
      while (!bus.rsp_valid_o && cyc <= 12) begin
         if ((v.is_div ? (div_en && div_sel && !mult_en && !mult_sel)
                       : (mult_en && mult_sel && !div_en && !div_sel)) && mdr)
            en++;
         if (cyc == v.vcyc) begin
            alu_valid  = 1'b1;
            alu_result = v.alu_res;
         end
         @(negedge clk);
         alu_valid  = 1'b0;
         alu_result = 32'd0;
         cyc++;
      end
      chk($sformatf("v%0d_rsp_valid", idx), 64'(bus.rsp_valid_o), 64'd1);
      chk($sformatf("v%0d_en_cycles", idx), 64'(en), 64'(v.exp_en));
      chk($sformatf("v%0d_result", idx), 64'(bus.rsp_result_o), 64'(v.exp_res));
      chk($sformatf("v%0d_timeout", idx), 64'(bus.rsp_timeout_o), 64'(v.exp_to));
      chk($sformatf("v%0d_done_en", idx), 64'({mult_en, div_en, mdr}), 64'd0);
      for (int h = 0; h < v.hold; h++) begin
         chk($sformatf("v%0d_hold%0d", idx, h),
             {30'd0, bus.rsp_valid_o, bus.req_ready_o, bus.rsp_result_o},
             {30'd0, 1'b1, 1'b0, v.exp_res});
         @(negedge clk);
      end
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
      chk($sformatf("v%0d_idle", idx), 64'({busy, bus.rsp_valid_o, bus.req_ready_o}), 64'd1);
      chk($sformatf("v%0d_ops", idx), 64'(ops_cnt), 64'(v.exp_ops));
   endtask

   initial begin
      //         is_div vcyc alu_res       hold en  exp_res       to    ops
      vecs[0] = '{1'b0, 3, 32'h1234_5678, 0, 3, 32'h1234_5678, 1'b0, 2'd1};
      vecs[1] = '{1'b1, 1, 32'hDEAD_BEEF, 5, 1, 32'hDEAD_BEEF, 1'b0, 2'd2};
      vecs[2] = '{1'b1, 0, 32'h0000_0000, 2, 4, 32'h0000_0000, 1'b1, 2'd2};
      vecs[3] = '{1'b0, 4, 32'hA5A5_0F0F, 0, 4, 32'hA5A5_0F0F, 1'b0, 2'd3};
      vecs[4] = '{1'b0, 2, 32'h0000_0001, 1, 2, 32'h0000_0001, 1'b0, 2'd0};
      vecs[5] = '{1'b0, 0, 32'h0000_0000, 0, 4, 32'h0000_0000, 1'b1, 2'd0};

      rst_ni           = 1'b0;
      bus.req_valid_i  = 1'b0;
      bus.req_is_div_i = 1'b0;
      bus.req_kill_i   = 1'b0;
      bus.rsp_ready_i  = 1'b0;
      imd_d[0]         = 34'd0;
      imd_d[1]         = 34'd0;
      imd_we           = 2'b00;
      alu_valid        = 1'b0;
      alu_result       = 32'd0;

      // Reset state
      @(negedge clk);
      chk("rst_ctrl", 64'({busy, bus.req_ready_o, bus.rsp_valid_o, mult_en, div_en,
                           mult_sel, div_sel, mdr}), 64'h40);
      chk("rst_rsp", {31'd0, bus.rsp_timeout_o, bus.rsp_result_o}, 64'd0);
      chk("rst_ops", 64'(ops_cnt), 64'd0);
      chk("rst_imd", 64'(imd_q[0] | imd_q[1]), 64'd0);
      rst_ni = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i], i);
      end

      // Intermediate registers: per-lane writes in RUN, ignored in DONE.
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      @(negedge clk);                        // RUN 1
      bus.req_valid_i = 1'b0;
      imd_we   = 2'b01;
      imd_d[0] = 34'h3_FFFF_FFFF;
      imd_d[1] = 34'h0_1234_5678;
      @(negedge clk);                        // RUN 2
      chk("imd0_write", 64'(imd_q[0]), 64'h3_FFFF_FFFF);
      chk("imd1_untouched", 64'(imd_q[1]), 64'd0);
      imd_we   = 2'b10;
      imd_d[0] = 34'd0;
      imd_d[1] = 34'h1_0000_0001;
      @(negedge clk);                        // RUN 3
      chk("imd1_write", 64'(imd_q[1]), 64'h1_0000_0001);
      chk("imd0_kept", 64'(imd_q[0]), 64'h3_FFFF_FFFF);
      imd_we     = 2'b00;
      alu_valid  = 1'b1;
      alu_result = 32'h0BAD_F00D;
      @(negedge clk);                        // DONE
      alu_valid  = 1'b0;
      alu_result = 32'd0;
      chk("imd_op_result", {31'd0, bus.rsp_valid_o, bus.rsp_result_o}, 64'h1_0BAD_F00D);
      imd_we   = 2'b11;
      imd_d[0] = 34'h0_5555_5555;
      imd_d[1] = 34'h0_5555_5555;
      @(negedge clk);
      chk("imd_done_ignored", 64'(imd_q[0]), 64'h3_FFFF_FFFF);
      imd_we          = 2'b00;
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);                        // IDLE
      bus.rsp_ready_i = 1'b0;
      bus.req_valid_i = 1'b1;
      @(negedge clk);                        // RUN 1 of the kill operation
      bus.req_valid_i = 1'b0;
      chk("imd_cleared_on_accept", 64'(imd_q[0] | imd_q[1]), 64'd0);
      chk("ops_after_imd_op", 64'(ops_cnt), 64'd1);

      // Kill in RUN cycle 2 together with alu_valid.
      imd_we   = 2'b11;
      imd_d[0] = 34'h2_AAAA_5555;
      imd_d[1] = 34'h1_5555_AAAA;
      @(negedge clk);                        // RUN 2
      imd_we = 2'b00;
      chk("kill_pre_imd", 64'(imd_q[0]), 64'h2_AAAA_5555);
      bus.req_kill_i = 1'b1;
      alu_valid      = 1'b1;
      alu_result     = 32'hFFFF_FFFF;
      @(negedge clk);
      bus.req_kill_i = 1'b0;
      alu_valid      = 1'b0;
      alu_result     = 32'd0;
      chk("kill_idle", 64'({busy, bus.req_ready_o, bus.rsp_valid_o, mult_en}), 64'h4);
      chk("kill_imd", 64'(imd_q[0] | imd_q[1]), 64'd0);
      chk("kill_ops", 64'(ops_cnt), 64'd1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("kill_no_rsp%0d", i), 64'(bus.rsp_valid_o), 64'd0);
      end

      // Kill together with a request in IDLE drops the request.
      bus.req_valid_i = 1'b1;
      bus.req_kill_i  = 1'b1;
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      bus.req_kill_i  = 1'b0;
      chk("idle_kill_busy", 64'({busy, mult_en, bus.req_ready_o}), 64'd1);

      // Asynchronous reset mid-RUN.
      bus.req_valid_i = 1'b1;
      @(negedge clk);                        // RUN 1
      bus.req_valid_i = 1'b0;
      imd_we   = 2'b01;
      imd_d[0] = 34'h0_0000_00FF;
      @(negedge clk);                        // RUN 2
      imd_we = 2'b00;
      chk("prereset_run", 64'({busy, mult_en, imd_q[0][7:0]}), 64'h3FF);
      #2 rst_ni = 1'b0;
      #1;
      chk("async_rst_ctrl", 64'({busy, bus.req_ready_o, bus.rsp_valid_o, mult_en,
                                 mult_sel, mdr}), 64'h10);
      chk("async_rst_imd", 64'(imd_q[0] | imd_q[1]), 64'd0);
      chk("async_rst_ops", 64'(ops_cnt), 64'd0);
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", 64'({busy, bus.rsp_valid_o, bus.req_ready_o}), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ibex_pext_multdiv_seq.md
Name: ibex_pext_multdiv_seq

Overview:
Sequencer for the multicycle multiply/divide path of the P-extension ALU (ibex_alu_pext).
- Accepts one operation at a time from the decode stage over a valid/ready handshake.
- Drives the ALU's mult/div enable and select inputs.
- Owns the two 34-bit intermediate-value registers the ALU reads back between cycles.
- Buffers the final result until the writeback side accepts it.
- Provides flush (kill) and a watchdog timeout.

Parameters:
IMD_W, 34, width of each intermediate-value register.
MAX_CYCLES, 40, cycles in RUN before the watchdog forces completion; legal range 2..255.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_ni  in  1  asynchronous, active-low reset.
req_valid_i  in  1  decode presents an operation.
req_ready_o  out  1  sequencer can accept an operation.
req_is_div_i  in  1  1 = divide/remainder class, 0 = multiply class; sampled on accept.
req_kill_i  in  1  flush: abort the current operation.
mult_en_o  out  1  to ALU mult_en_i.
div_en_o  out  1  to ALU div_en_i.
mult_sel_o  out  1  to ALU mult_sel_i.
div_sel_o  out  1  to ALU div_sel_i.
multdiv_ready_id_o  out  1  to ALU multdiv_ready_id_i.
imd_val_d_i  in  2 x IMD_W  from ALU imd_val_d_o.
imd_val_we_i  in  2  from ALU imd_val_we_o.
imd_val_q_o  out  2 x IMD_W  to ALU imd_val_q_i.
alu_valid_i  in  1  ALU valid_o.
alu_result_i  in  32  ALU result_o.
rsp_valid_o  out  1  result available.
rsp_ready_i  in  1  consumer accepts the result.
rsp_result_o  out  32  buffered result.
rsp_timeout_o  out  1  qualifies rsp_valid_o: the result came from a watchdog abort.
busy_o  out  1  state != IDLE.
ops_cnt_o  out  CNT_W  operations completed normally.

Behaviour:
Reset values:
- state = IDLE.
- imd_val_q_o, rsp_result_o, rsp_timeout_o, ops_cnt_o and the cycle counter = 0.
- All enable/select outputs = 0; rsp_valid_o = 0; busy_o = 0.
- req_ready_o = 1, since it decodes directly from IDLE.

States: IDLE, RUN, DONE. All outputs decode from registered state and flags only; there is no combinational path from req_* to mult/div outputs.

IDLE:
- req_ready_o = 1.
- If req_valid_i = 1 and req_kill_i = 0: latch is_div, clear both imd registers, clear the cycle counter, go to RUN.
- If req_kill_i = 1 in the same cycle, the request is dropped and state stays IDLE.

RUN:
- mult_en_o = mult_sel_o = ~is_div; div_en_o = div_sel_o = is_div; multdiv_ready_id_o = 1.
- imd_val_q_o[r] <= imd_val_d_i[r] when imd_val_we_i[r]. Writes outside RUN are ignored.
- Cycle counter increments every RUN cycle.
- alu_valid_i = 1: capture alu_result_i into rsp_result_o, clear rsp_timeout_o, ops_cnt_o += 1 (wraps modulo 2^CNT_W), go to DONE.
- Watchdog: if the counter equals MAX_CYCLES-1 and alu_valid_i = 0, then rsp_result_o = 0, rsp_timeout_o = 1, go to DONE. ops_cnt_o is not incremented.
- If alu_valid_i = 1 on the watchdog cycle, the valid result wins.

DONE:
- rsp_valid_o = 1; all enables = 0; multdiv_ready_id_o = 0.
- rsp_result_o and rsp_timeout_o stay stable while rsp_ready_i = 0.
- On rsp_ready_i = 1: go to IDLE. There is no same-cycle accept of a new request; req_ready_o is 0 in DONE.

Kill:
- req_kill_i in RUN or DONE has priority over every other event: next state IDLE, imd registers cleared, no response delivered, ops_cnt_o unchanged.
- A kill coinciding with alu_valid_i discards the result.

Latency:
- Accept at edge N. First enabled ALU cycle is N+1.
- If alu_valid_i rises in cycle N+k, rsp_valid_o is high from N+k+1.
- Back-to-back throughput: one operation per (k + 2) cycles when rsp_ready_i is held at 1.

Reset: asynchronous assertion mid-operation immediately returns all state to reset values; no response is delivered.

Test Plan:
1. Multiply: accept with req_is_div_i = 0; ALU valid on the 3rd RUN cycle with result 0x1234_5678 -> mult_en_o/mult_sel_o = 1 for exactly 3 cycles, then rsp_valid_o = 1 with rsp_result_o = 0x12345678, rsp_timeout_o = 0, ops_cnt_o = 1.
2. Intermediate registers: in RUN drive imd_val_we_i = 2'b01, imd_val_d_i[0] = 0x3_FFFF_FFFF, then 2'b10 with [1] = 0x1_0000_0001 -> imd_val_q_o[0] and [1] update one cycle later each. A new accept clears both to 0.
3. Backpressure: divide completes while rsp_ready_i = 0 for 5 cycles -> rsp_valid_o and rsp_result_o stable for all 5; req_ready_o = 0 throughout; IDLE the cycle after rsp_ready_i = 1.
4. Kill: assert req_kill_i in RUN cycle 2 together with alu_valid_i -> IDLE next cycle, rsp_valid_o never asserts, imd_val_q_o = 0, ops_cnt_o unchanged. A kill with req_valid_i in IDLE leaves busy_o = 0.
5. Watchdog: MAX_CYCLES = 4, alu_valid_i held at 0 -> exactly 4 RUN cycles, then rsp_valid_o = 1, rsp_timeout_o = 1, rsp_result_o = 0, ops_cnt_o unchanged.
6. Reset and wrap: rst_ni low mid-RUN -> all outputs at reset values asynchronously. With CNT_W = 2, four completions -> ops_cnt_o = 0.
